// File: rtl/compute_scheduler.sv
// compute_scheduler: queues engine commands in a FIFO and sequences one engine at a time
// through start, run and response, with timeout, abort and an OK-completion counter.
module compute_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_ENG    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [3:0]          cmd_len,
    output logic [NUM_ENG-1:0]  eng_start,
    output logic [NUM_ENG-1:0]  eng_working,
    input  logic [NUM_ENG-1:0]  eng_done,
    output logic [3:0]          vector_length,
    output logic [1:0]          sel,
    input  logic [15:0]         timeout_cycles,
    input  logic                abort,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic                busy,
    output logic [7:0]          done_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;
    state_t state_q, state_d;
    logic [1:0] op_mem_q [FIFO_DEPTH];
    logic [1:0] op_mem_d [FIFO_DEPTH];
    logic [3:0] len_mem_q [FIFO_DEPTH];
    logic [3:0] len_mem_d [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [1:0] sel_q, sel_d, status_q, status_d;
    logic [3:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic empty, full, push, pop, hit, timeout;
    logic [1:0] head_op;
    logic [3:0] head_len;
    logic [NUM_ENG-1:0] onehot;

    always_comb begin
        empty = wr_q == rd_q;
        full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop = (state_q == IDLE) && !empty;
        // a pop frees a slot this cycle, so a full FIFO can still accept
        cmd_ready = !full || pop;
        push = cmd_valid && cmd_ready;
        head_op = op_mem_q[rd_q[AW-1:0]];
        head_len = len_mem_q[rd_q[AW-1:0]];
        onehot = NUM_ENG'(1) << sel_q;
        hit = |(eng_done & onehot);
        timeout = (timeout_cycles != 16'd0) && (cnt_q + 16'd1 == timeout_cycles);
        op_mem_d = op_mem_q;
        len_mem_d = len_mem_q;
        if (push) begin
            op_mem_d[wr_q[AW-1:0]] = cmd_op;
            len_mem_d[wr_q[AW-1:0]] = cmd_len;
        end
        wr_d = wr_q + (AW+1)'(push);
        rd_d = rd_q + (AW+1)'(pop);
        state_d = state_q;
        sel_d = sel_q;
        len_d = len_q;
        status_d = status_q;
        cnt_d = cnt_q;
        dcnt_d = dcnt_q;
        case (state_q)
            IDLE: if (!empty) begin
                sel_d = head_op;
                len_d = head_len;
                status_d = 2'd0;
                state_d = START;
                if (head_len < 4'd2 || int'(head_op) >= NUM_ENG) begin
                    status_d = 2'd3;
                    state_d = RESP;
                end
            end
            START: begin
                cnt_d = 16'd0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 16'd1;
                state_d = (abort || hit || timeout) ? RESP : RUN;
                status_d = abort ? 2'd2 : hit ? 2'd0 : 2'd1;
            end
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                dcnt_d = dcnt_q + 8'(status_q == 2'd0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_mem_q <= '{default: '0};
            len_mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            sel_q <= '0;
            len_q <= '0;
            status_q <= '0;
            cnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            state_q <= state_d;
            op_mem_q <= op_mem_d;
            len_mem_q <= len_mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            sel_q <= sel_d;
            len_q <= len_d;
            status_q <= status_d;
            cnt_q <= cnt_d;
            dcnt_q <= dcnt_d;
        end
    end

    // engine controls decode straight from the state flop so reset drops them at once
    assign eng_start = (state_q == START) ? onehot : '0;
    assign eng_working = (state_q == START || state_q == RUN) ? onehot : '0;
    assign rsp_valid = state_q == RESP;
    assign rsp_status = status_q;
    assign sel = sel_q;
    assign vector_length = len_q;
    assign busy = (state_q != IDLE) || !empty;
    assign done_count = dcnt_q;
endmodule

// File: tb/tb_compute_scheduler.sv
// tb_compute_scheduler: directed scenarios with a response scoreboard; a monitor pops
// expected {status, sel, len} on every accepted response.
module tb_compute_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_len = '0;
    logic [2:0] eng_start, eng_working;
    logic [2:0] eng_done = '0;
    logic [3:0] vector_length;
    logic [1:0] sel;
    logic [15:0] timeout_cycles = '0;
    logic abort = 1'b0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [1:0] rsp_status;
    logic busy;
    logic [7:0] done_count;

    typedef struct packed {logic [1:0] st; logic [1:0] op; logic [3:0] len;} exp_t;
    exp_t sb[$];
    int vecs = 0;
    int errs = 0;
    int es_cnt = 0;
    logic [2:0] es_mask = '0;
    logic [2:0] es_d = '0;
    int done_dly = 0;

    compute_scheduler #(.FIFO_DEPTH(4), .NUM_ENG(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .eng_start(eng_start), .eng_working(eng_working),
        .eng_done(eng_done), .vector_length(vector_length), .sel(sel),
        .timeout_cycles(timeout_cycles), .abort(abort), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_status(rsp_status), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_rsp: got status %0d expected no response", rsp_status);
            end else begin
                e = sb.pop_front();
                check("rsp_status", int'(rsp_status), int'(e.st));
                check("rsp_sel", int'(sel), int'(e.op));
                check("rsp_len", int'(vector_length), int'(e.len));
            end
        end
    end

    // engine model: pulses done on the started engine done_dly cycles after start (0 = never)
    initial forever begin
        @(negedge clk);
        if (eng_start != 3'd0) begin
            es_cnt++;
            es_mask = es_mask | eng_start;
            es_d = eng_start;
            if (done_dly > 0) begin
                repeat (done_dly) @(negedge clk);
                eng_done = es_d;
                @(negedge clk);
                eng_done = '0;
            end
        end
    end

    task automatic push(input logic [1:0] op, input logic [3:0] len, input logic [1:0] st, input bit track);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_len = len;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            vecs++;
            errs++;
            $display("FAIL push_wait: got cmd_ready 0 expected 1 within 500 cycles");
        end else if (track) begin
            sb.push_back({st, op, len});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rsp_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy || rsp_valid) begin
            vecs++;
            errs++;
            $display("FAIL wait_idle: got busy %0d expected 0 within 1000 cycles", busy);
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (!(eng_working != 3'd0 && eng_start == 3'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (eng_working == 3'd0) begin
            vecs++;
            errs++;
            $display("FAIL wait_run: got eng_working 0 expected nonzero within 200 cycles");
        end
    endtask

    initial begin
        int n;
        int w;
        int stable;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_eng_start", int'(eng_start), 0);
        check("rst_eng_working", int'(eng_working), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_status", int'(rsp_status), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_vector_length", int'(vector_length), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_count", int'(done_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        done_dly = 10;
        push(2'd1, 4'd4, 2'd0, 1'b1);
        wait_idle();
        check("basic_start_pulses", es_cnt, 1);
        check("basic_start_mask", int'(es_mask), 2);
        check("basic_done_count", int'(done_count), 1);

        done_dly = 1;
        push(2'd2, 4'd5, 2'd0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("min_latency", n, 3);
        wait_idle();
        check("latency_done_count", int'(done_count), 2);

        done_dly = 0;
        timeout_cycles = 16'd8;
        push(2'd0, 4'd3, 2'd1, 1'b1);
        n = 0;
        w = 0;
        while (!rsp_valid && n < 100) begin
            if (eng_working != 3'd0 && eng_start == 3'd0) w++;
            @(negedge clk);
            n++;
        end
        check("timeout_run_cycles", w, 8);
        check("resp_working_low", int'(eng_working), 0);
        wait_idle();
        check("timeout_done_count", int'(done_count), 2);
        timeout_cycles = 16'd0;

        push(2'd0, 4'd1, 2'd3, 1'b1);
        push(2'd3, 4'd5, 2'd3, 1'b1);
        wait_idle();
        check("illegal_no_start", es_cnt, 3);
        check("illegal_done_count", int'(done_count), 2);

        rsp_ready = 1'b0;
        push(2'd2, 4'd6, 2'd2, 1'b1);
        push(2'd1, 4'd2, 2'd0, 1'b1);
        wait_run();
        eng_done = 3'b011;
        @(negedge clk);
        eng_done = '0;
        check("other_done_ignored", int'(eng_working), 4);
        abort = 1'b1;
        eng_done = 3'b100;
        @(negedge clk);
        abort = 1'b0;
        eng_done = '0;
        stable = 0;
        repeat (5) begin
            if (rsp_valid && rsp_status == 2'd2 && sel == 2'd2 && vector_length == 4'd6 && eng_start == 3'd0) stable++;
            @(negedge clk);
        end
        check("resp_hold_stable", stable, 5);
        check("held_no_next_start", es_cnt, 4);
        done_dly = 2;
        rsp_ready = 1'b1;
        wait_idle();
        check("abort_done_count", int'(done_count), 3);
        check("abort_next_started", es_cnt, 5);

        rsp_ready = 1'b0;
        done_dly = 1;
        push(2'd0, 4'd2, 2'd0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        push(2'd0, 4'd3, 2'd0, 1'b1);
        push(2'd1, 4'd4, 2'd0, 1'b1);
        push(2'd2, 4'd5, 2'd0, 1'b1);
        push(2'd0, 4'd6, 2'd0, 1'b1);
        check("full_cmd_ready", int'(cmd_ready), 0);
        check("full_busy", int'(busy), 1);
        rsp_ready = 1'b1;
        push(2'd1, 4'd7, 2'd0, 1'b1);
        wait_idle();
        check("fifo_done_count", int'(done_count), 9);
        check("fifo_start_pulses", es_cnt, 11);

        done_dly = 0;
        push(2'd0, 4'd4, 2'd0, 1'b0);
        wait_run();
        push(2'd1, 4'd3, 2'd0, 1'b0);
        push(2'd2, 4'd3, 2'd0, 1'b0);
        check("pre_reset_working", int'(eng_working), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_working_drop", int'(eng_working), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            if (rsp_valid) n++;
            @(negedge clk);
        end
        check("post_reset_no_rsp", n, 0);
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_done_count", int'(done_count), 0);
        check("post_reset_no_start", es_cnt, 12);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end
endmodule
